// File: rtl/flash_seq_pkg.sv
// flash_seq_pkg: state encoding and direction bit positions shared by the flash address sequencer.
package flash_seq_pkg;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_STEP} state_t;
    localparam int DIR_PLAY_BIT = 1;
    localparam int DIR_REV_BIT  = 0;
endpackage

// File: rtl/addr_step_calc.sv
// addr_step_calc: next flash address with wrap/stop detection at the programmable region bounds.
module addr_step_calc #(
    parameter int                ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'('h7FFFF),
    parameter logic [ADDR_W:0]   STEP       = (ADDR_W+1)'(1)
) (
    input  logic [ADDR_W-1:0] address,
    input  logic              reverse,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] next_addr,
    output logic              wrap,
    output logic              hit_bound
);
    localparam int W = ADDR_W + 2;
    logic [W-1:0] fwd, rev;
    logic over, under, oob;
    // Two guard bits: the sign of (bound - candidate) flags overflow and borrow without constant compares.
    assign fwd       = W'(address) + W'(STEP);
    assign rev       = W'(address) - W'(STEP);
    assign over      = 1'((W'(END_ADDR) - fwd) >> (W-1));
    assign under     = 1'((rev - W'(START_ADDR)) >> (W-1));
    assign oob       = reverse ? under : over;
    assign wrap      = oob && loop_en;
    assign hit_bound = oob && !loop_en;
    assign next_addr = !oob ? (reverse ? ADDR_W'(rev) : ADDR_W'(fwd)) :
                       loop_en ? (reverse ? END_ADDR : START_ADDR) : address;
endmodule

// File: rtl/flash_addr_sequencer.sv
// flash_addr_sequencer: steps a flash word address per sample tick and issues one held read
// request per step, with pause, loop/one-shot, restart and overrun reporting.
module flash_addr_sequencer
    import flash_seq_pkg::*;
#(
    parameter int                ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'('h7FFFF),
    parameter logic [ADDR_W:0]   STEP       = (ADDR_W+1)'(1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        direction,
    input  logic              loop_en,
    input  logic              restart,
    input  logic              advance,
    input  logic              rd_ack,
    output logic [ADDR_W-1:0] address,
    output logic              rd_req,
    output logic              start,
    output logic              done,
    output logic              wrapped,
    output logic              overrun
);
    state_t state, state_nxt;
    logic [ADDR_W-1:0] calc_addr;
    logic calc_wrap, calc_hit, rev, rev_q, restart_pend, jump;

    addr_step_calc #(
        .ADDR_W(ADDR_W), .START_ADDR(START_ADDR), .END_ADDR(END_ADDR), .STEP(STEP)
    ) u_calc (
        .address(address), .reverse(rev), .loop_en(loop_en),
        .next_addr(calc_addr), .wrap(calc_wrap), .hit_bound(calc_hit)
    );

    assign rev    = direction[DIR_REV_BIT];
    assign rd_req = state == S_REQ;
    // A restart seen during a request replaces the step that follows it.
    assign jump   = state == S_IDLE ? restart : state == S_STEP && (restart || restart_pend);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        state_nxt = state == S_IDLE ? (advance && direction[DIR_PLAY_BIT] && !done && !restart ? S_REQ : S_IDLE) :
                    state == S_REQ  ? (rd_ack ? S_STEP : S_REQ) : S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            address      <= START_ADDR;
            restart_pend <= 1'b0;
            rev_q        <= 1'b0;
            start        <= 1'b0;
            done         <= 1'b0;
            wrapped      <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            start        <= rd_req && rd_ack;
            overrun      <= advance && state != S_IDLE;
            restart_pend <= state == S_REQ && (restart_pend || restart);
            rev_q        <= rev;
            wrapped      <= 1'b0;
            if (rev != rev_q) done <= 1'b0;
            if (jump) begin
                address <= rev ? END_ADDR : START_ADDR;
                done    <= 1'b0;
            end else if (state == S_STEP) begin
                address <= calc_addr;
                wrapped <= calc_wrap;
                if (calc_hit) done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_flash_addr_sequencer.sv
// tb_flash_addr_sequencer: directed checks of stepping, bounds, pause, overrun, restart and async reset.
module tb_flash_addr_sequencer;
    logic       clk = 1'b0, reset = 1'b1;
    logic [1:0] direction = 2'b00, b_dir = 2'b00;
    logic       loop_en = 1'b1, restart = 1'b0, advance = 1'b0, rd_ack = 1'b0;
    logic       b_adv = 1'b0, b_ack = 1'b0, b_restart = 1'b0;
    logic [7:0] address, b_addr;
    logic       rd_req, start, done, wrapped, overrun;
    logic       b_req, b_start, b_done, b_wrapped, b_overrun;
    int         passed = 0, total = 0;

    always #5 clk = ~clk;

    flash_addr_sequencer #(.ADDR_W(8), .START_ADDR(8'd4), .END_ADDR(8'd10), .STEP(9'd2)) dut (
        .clk(clk), .reset(reset), .direction(direction), .loop_en(loop_en), .restart(restart),
        .advance(advance), .rd_ack(rd_ack), .address(address), .rd_req(rd_req), .start(start),
        .done(done), .wrapped(wrapped), .overrun(overrun)
    );

    // Second instance with the region starting at 0 exercises the reverse borrow path.
    flash_addr_sequencer #(.ADDR_W(8), .START_ADDR(8'd0), .END_ADDR(8'd10), .STEP(9'd2)) dut_b (
        .clk(clk), .reset(reset), .direction(b_dir), .loop_en(loop_en), .restart(b_restart),
        .advance(b_adv), .rd_ack(b_ack), .address(b_addr), .rd_req(b_req), .start(b_start),
        .done(b_done), .wrapped(b_wrapped), .overrun(b_overrun)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic rd(input logic [7:0] a);
        advance = 1'b1;
        tick;
        advance = 1'b0;
        chk("rd_req_up", rd_req, 1);
        chk("req_addr", address, a);
        tick;
        rd_ack = 1'b1;
        tick;
        rd_ack = 1'b0;
        chk("start_pulse", start, 1);
        chk("addr_held", address, a);
        tick;
        chk("start_once", start, 0);
        chk("rd_req_down", rd_req, 0);
    endtask

    initial begin
        tick;
        tick;
        chk("rst_addr", address, 4);
        chk("rst_req", rd_req, 0);
        chk("rst_start", start, 0);
        chk("rst_done", done, 0);
        chk("rst_wrapped", wrapped, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_b_addr", b_addr, 0);
        reset = 1'b0;
        tick;
        b_dir = 2'b11;
        b_adv = 1'b1;
        tick;
        b_adv = 1'b0;
        chk("b_req", b_req, 1);
        tick;
        b_ack = 1'b1;
        tick;
        b_ack = 1'b0;
        tick;
        chk("b_borrow_addr", b_addr, 10);
        chk("b_borrow_wrap", b_wrapped, 1);
        direction = 2'b10;
        for (int i = 0; i < 4; i++) begin
            rd(8'(4 + 2 * i));
            chk("fwd_addr", address, i < 3 ? 6 + 2 * i : 4);
            chk("fwd_wrap", wrapped, i == 3);
        end
        tick;
        chk("wrap_pulse_end", wrapped, 0);
        direction = 2'b00;
        advance = 1'b1;
        tick;
        tick;
        advance = 1'b0;
        chk("pause_req", rd_req, 0);
        chk("pause_addr", address, 4);
        direction = 2'b10;
        advance = 1'b1;
        tick;
        chk("ovr_req", rd_req, 1);
        chk("ovr_none_yet", overrun, 0);
        tick;
        advance = 1'b0;
        chk("ovr_pulse", overrun, 1);
        rd_ack = 1'b1;
        tick;
        rd_ack = 1'b0;
        chk("ovr_clear", overrun, 0);
        chk("ovr_start", start, 1);
        tick;
        tick;
        chk("ovr_single", rd_req, 0);
        chk("ovr_addr", address, 6);
        loop_en = 1'b0;
        rd(6);
        rd(8);
        chk("os_addr10", address, 10);
        chk("os_not_done", done, 0);
        rd(10);
        chk("os_done", done, 1);
        chk("os_hold", address, 10);
        chk("os_no_wrap", wrapped, 0);
        advance = 1'b1;
        tick;
        advance = 1'b0;
        tick;
        chk("os_dropped", rd_req, 0);
        chk("os_addr_kept", address, 10);
        direction = 2'b11;
        tick;
        chk("dir_clears_done", done, 0);
        loop_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd(8'(10 - 2 * i));
            chk("rev_addr", address, i < 3 ? 8 - 2 * i : 10);
            chk("rev_wrap", wrapped, i == 3);
        end
        loop_en = 1'b0;
        for (int i = 0; i < 4; i++) rd(8'(10 - 2 * i));
        chk("rev_os_addr", address, 4);
        chk("rev_os_done", done, 1);
        restart = 1'b1;
        advance = 1'b1;
        tick;
        restart = 1'b0;
        advance = 1'b0;
        chk("rst_idle_addr", address, 10);
        chk("rst_idle_done", done, 0);
        chk("rst_idle_noreq", rd_req, 0);
        tick;
        chk("rst_idle_noreq2", rd_req, 0);
        direction = 2'b10;
        loop_en = 1'b1;
        tick;
        rd(10);
        chk("fwd_from_end", address, 4);
        rd(4);
        rd(6);
        advance = 1'b1;
        tick;
        advance = 1'b0;
        restart = 1'b1;
        tick;
        restart = 1'b0;
        chk("rreq_held", rd_req, 1);
        chk("rreq_addr", address, 8);
        rd_ack = 1'b1;
        tick;
        rd_ack = 1'b0;
        chk("rreq_start", start, 1);
        tick;
        chk("rreq_addr_new", address, 4);
        chk("rreq_no_wrap", wrapped, 0);
        chk("rreq_done", done, 0);
        rd(4);
        advance = 1'b1;
        tick;
        advance = 1'b0;
        chk("mid_req", rd_req, 1);
        chk("mid_addr", address, 6);
        #2 reset = 1'b1;
        #1;
        chk("async_req", rd_req, 0);
        chk("async_start", start, 0);
        chk("async_done", done, 0);
        chk("async_addr", address, 4);
        tick;
        reset = 1'b0;
        tick;
        chk("post_rst_req", rd_req, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
